multicycle_controller: RTL

//  Moore-FSM control unit for the multicycle RV32I core; sits directly upstream of the datapath.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// Decode fields and flags flow in; selects, enables and status flow out.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7;
  logic [3:0]       Flags;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ImmSrc;
  logic [3:0]       ALUControl;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] Retired;

  modport master (
    input  op, funct3, funct7, Flags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    output Illegal, State, Retired
  );

  modport slave (
    output op, funct3, funct7, Flags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    input  Illegal, State, Retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core, with a
// retired-instruction counter and a sticky illegal-instruction flag.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic RESET,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    JALR     = 4'd10,
    JALR2    = 4'd11,
    BRANCH   = 4'd12,
    LUI      = 4'd13,
    AUIPC    = 4'd14,
    ERROR    = 4'd15
  } state_t;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_PSB = 4'hA;

  state_t           state, next;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic [3:0]       alu_dec;
  logic             taken;
  logic             bad_br;
  logic             retire;

  // State register, aborted straight to FETCH on reset
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= next;
  end

  assign retire = (next == FETCH) &&
    (state == MEMWB || state == MEMWRITE ||
     state == ALUWB || state == BRANCH);

  // Retired counter and sticky trap
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      if (next == ERROR) illegal <= 1'b1;
    end
  end

  // ALU operation from funct3; SUB only for register-register forms
  always_comb begin
    alu_dec = A_ADD;
    unique case (bus.funct3)
      3'b000: alu_dec = (state == EXECR && bus.funct7) ? A_SUB : A_ADD;
      3'b001: alu_dec = 4'h5;
      3'b010: alu_dec = 4'h8;
      3'b011: alu_dec = 4'h9;
      3'b100: alu_dec = 4'h4;
      3'b101: alu_dec = bus.funct7 ? 4'h7 : 4'h6;
      3'b110: alu_dec = 4'h3;
      3'b111: alu_dec = 4'h2;
      default: alu_dec = A_ADD;
    endcase
  end

  // Branch condition from NZCV of rs1 - rs2
  always_comb begin
    taken  = 1'b0;
    bad_br = 1'b0;
    unique case (bus.funct3)
      3'b000: taken = bus.Flags[2];
      3'b001: taken = !bus.Flags[2];
      3'b100: taken = bus.Flags[3] ^ bus.Flags[0];
      3'b101: taken = !(bus.Flags[3] ^ bus.Flags[0]);
      3'b110: taken = !bus.Flags[1];
      3'b111: taken = bus.Flags[1];
      default: bad_br = 1'b1;
    endcase
  end

  // Next state and per-state datapath controls
  always_comb begin
    next           = state;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ImmSrc     = 3'b000;
    bus.ALUControl = A_ADD;
    unique case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        next          = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 3'b010;
        unique case (bus.op)
          7'b0000011,
          7'b0100011: next = MEMADR;
          7'b0110011: next = EXECR;
          7'b0010011: next = EXECI;
          7'b1101111: next = JAL;
          7'b1100111: next = JALR;
          7'b1100011: next = BRANCH;
          7'b0110111: next = LUI;
          7'b0010111: next = AUIPC;
          default:    next = ERROR;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = bus.op[5] ? 3'b001 : 3'b000;
        next        = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        next       = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        next          = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        next         = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_dec;
        next           = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec;
        next           = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        next         = FETCH;
      end
      JAL, JALR2: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        next        = ALUWB;
      end
      JALR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next        = JALR2;
      end
      BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = A_SUB;
        bus.PCWrite    = taken && !bad_br;
        next           = bad_br ? ERROR : FETCH;
      end
      LUI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ImmSrc     = 3'b011;
        bus.ALUControl = A_PSB;
        next           = ALUWB;
      end
      AUIPC: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 3'b011;
        next        = ALUWB;
      end
      ERROR: next = ERROR;
      default: next = ERROR;
    endcase
  end

  assign bus.Illegal = illegal;
  assign bus.State   = state;
  assign bus.Retired = retired;
endmodule
